// File: rtl/axis_exer_pkg.sv
// Shared types and helpers for the AXI-Stream memory exerciser: FSM state
// enumeration, beat pattern generator and saturating adder.
package axis_exer_pkg;

  localparam int unsigned PAT_MAX_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } exer_state_e;

  // Beat i carries seed + i; callers truncate to their data width, which
  // gives the modulo-2^DATA_WIDTH wrap.
  function automatic logic [PAT_MAX_W-1:0] pattern(input logic [PAT_MAX_W-1:0] seed,
                                                   input logic [PAT_MAX_W-1:0] idx);
    return seed + idx;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/axis_mem_exerciser_if.sv
// Stream bundle between the exerciser and the memory controller: the write
// stream (exerciser -> controller) and the read stream (controller -> exerciser).
interface axis_mem_exerciser_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   m00_axis_wr_tdata;
  logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                    m00_axis_tvalid;
  logic                    m00_axis_tlast;
  logic                    m00_axis_tready;
  logic [DATA_WIDTH-1:0]   s00_axis_rd_tdata;
  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb;
  logic                    s00_axis_tvalid;
  logic                    s00_axis_tlast;
  logic                    s00_axis_tready;

  modport master (
    output m00_axis_wr_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
    input  m00_axis_tready,
    input  s00_axis_rd_tdata, s00_axis_tstrb, s00_axis_tvalid, s00_axis_tlast,
    output s00_axis_tready
  );

  modport slave (
    input  m00_axis_wr_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
    output m00_axis_tready,
    output s00_axis_rd_tdata, s00_axis_tstrb, s00_axis_tvalid, s00_axis_tlast,
    input  s00_axis_tready
  );
endinterface

// File: rtl/axis_exer_checker.sv
// Read-beat checker: data and tlast compare, one error per bad beat, plus an
// optional bulk penalty, accumulated into a saturating error counter.
module axis_exer_checker
  import axis_exer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  clear,
  input  logic                  beat_fire,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_last,
  input  logic [DATA_WIDTH-1:0] rd_tdata,
  input  logic                  rd_tlast,
  input  logic                  pen_en,
  input  logic [CNT_WIDTH-1:0]  pen_cnt,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  err_next
);

  localparam logic [31:0] ERR_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic        beat_bad;
  logic [31:0] inc;

  assign beat_bad = beat_fire && ((rd_tdata != exp_data) || (rd_tlast != exp_last));

  always_comb begin
    inc = '0;
    if (beat_bad) inc = 32'd1;
    if (pen_en)   inc = inc + 32'(pen_cnt);
    err_next = clear ? '0 : CNT_WIDTH'(sat_add(32'(err_count), inc, ERR_MAX));
  end

  always_ff @(posedge aclk) begin
    if (areset) err_count <= '0;
    else        err_count <= err_next;
  end

endmodule

// File: rtl/axis_mem_exerciser.sv
// Stream-side memory exerciser: writes a seed+i burst, reads it back and checks it.
// Optional read watchdog enabled by defining AXIS_EXER_WATCHDOG_EN.
module axis_mem_exerciser
  import axis_exer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned CNT_WIDTH      = 13,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  axis_mem_exerciser_if.master  bus
);

  localparam int unsigned          STRB_W   = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);

  exer_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d, beat_inc;
  logic [DATA_WIDTH-1:0] seed_q, seed_d, wdata_q, wdata_d, exp_data;
  logic                  wvalid_q, wvalid_d, wlast_q, wlast_d, rready_q, rready_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                  wr_fire, rd_fire, clr_errs, pen_en;
  logic [CNT_WIDTH-1:0]  pen_cnt, err_next;
  logic                  unused_rd_strb;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                input logic [CNT_WIDTH-1:0]  i);
    return DATA_WIDTH'(pattern(PAT_MAX_W'(s), PAT_MAX_W'(i)));
  endfunction

  assign wr_fire        = wvalid_q && bus.m00_axis_tready;
  assign rd_fire        = rready_q && bus.s00_axis_tvalid;
  assign beat_inc       = beat_q + 1'b1;
  assign exp_data       = pat(seed_q, beat_q);
  assign unused_rd_strb = ^bus.s00_axis_tstrb;

`ifdef AXIS_EXER_WATCHDOG_EN
  logic [31:0] wd_q;
  // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle READ cycle.
  assign pen_en  = (state_q == READ) && !rd_fire && (wd_q == 32'(TIMEOUT_CYCLES - 1));
  assign pen_cnt = CNT_WIDTH'(BURST_LEN) - beat_q;

  always_ff @(posedge aclk) begin
    if (areset || state_q != READ || rd_fire) wd_q <= '0;
    else                                      wd_q <= wd_q + 32'd1;
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign pen_en  = 1'b0;
  assign pen_cnt = '0;
`endif

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    seed_d   = seed_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    wlast_d  = wlast_q;
    rready_d = rready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    clr_errs = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = WRITE;
        seed_d   = seed;
        beat_d   = '0;
        clr_errs = 1'b1;
        busy_d   = 1'b1;
        pass_d   = 1'b0;
        wvalid_d = 1'b1;
        wdata_d  = pat(seed, '0);
        wlast_d  = (BURST_LEN == 1);
      end
      WRITE: if (wr_fire) begin
        if (beat_q == LAST_IDX) begin
          state_d  = READ;
          beat_d   = '0;
          wvalid_d = 1'b0;
          wdata_d  = '0;
          wlast_d  = 1'b0;
          rready_d = 1'b1;
        end else begin
          beat_d  = beat_inc;
          wdata_d = pat(seed_q, beat_inc);
          wlast_d = (beat_inc == LAST_IDX);
        end
      end
      READ: begin
        // pass is taken from the checker's next value so it covers the final beat.
        if ((rd_fire && beat_q == LAST_IDX) || pen_en) begin
          state_d  = DONE;
          beat_d   = '0;
          rready_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (err_next == '0) && !pen_en;
        end else if (rd_fire) begin
          beat_d = beat_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      seed_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      rready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      seed_q   <= seed_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wlast_q  <= wlast_d;
      rready_q <= rready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  axis_exer_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_checker (
    .aclk      (aclk),
    .areset    (areset),
    .clear     (clr_errs),
    .beat_fire (rd_fire),
    .exp_data  (exp_data),
    .exp_last  (beat_q == LAST_IDX),
    .rd_tdata  (bus.s00_axis_rd_tdata),
    .rd_tlast  (bus.s00_axis_tlast),
    .pen_en    (pen_en),
    .pen_cnt   (pen_cnt),
    .err_count (err_count),
    .err_next  (err_next)
  );

  assign bus.m00_axis_wr_tdata = wdata_q;
  assign bus.m00_axis_tstrb    = {STRB_W{wvalid_q}};
  assign bus.m00_axis_tvalid   = wvalid_q;
  assign bus.m00_axis_tlast    = wlast_q;
  assign bus.s00_axis_tready   = rready_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign pass                  = pass_q;

endmodule

// File: tb/tb_axis_mem_exerciser.sv
// Testbench for axis_mem_exerciser: the bench plays the memory controller and
// checks the write stream and run results against a seed+i reference model.
module tb_axis_mem_exerciser;

  localparam int unsigned DW = 32, BL = 4, CW = 13, TO = 8, LIMIT = 300;

  logic          aclk = 1'b0;
  logic          areset, start, busy, done, pass;
  logic [DW-1:0] seed;
  logic [CW-1:0] err_count;

  axis_mem_exerciser_if #(.DATA_WIDTH(DW)) bus ();

  axis_mem_exerciser #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .seed(seed), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int unsigned n_tests = 0, n_fail = 0;

  // Observations from the most recent run.
  logic [31:0] wr_data_q[$];
  logic        wr_last_q[$];
  logic [31:0] rd_src_data[BL];
  logic        rd_src_last[BL];
  logic [CW-1:0] err_trace[BL];
  logic        loopback;
  int unsigned hold_bad, extra_wr, to_flag, rd_cycles, n_rd;
  logic        lat_ok, busy_ok, done_seen, pass_o, done_after, busy_after, pass_hold;
  logic [CW-1:0] err_o, err_hold;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: a beat is bad if its data is not seed+i or its tlast is not (i == last).
  function automatic int unsigned model_errs(input logic [31:0] s);
    int unsigned e = 0;
    for (int i = 0; i < BL; i++)
      if (rd_src_data[i] !== s + 32'(i) || rd_src_last[i] !== (i == BL - 1)) e++;
    return e;
  endfunction

  // wr_mode: 0 ready, 1 toggle 1/0, 2 random. rd_mode: 0 valid, 1 random, 2 never, 3 after 40 cycles.
  task automatic do_run(input logic [31:0] s, input int wr_mode, input int rd_mode, input bit spam);
    int unsigned guard;
    logic stalled, hl, rdy, vld, fired;
    logic [31:0] hd;
    wr_data_q.delete(); wr_last_q.delete();
    hold_bad = 0; extra_wr = 0; to_flag = 0; rd_cycles = 0; n_rd = 0;
    start = 1'b1; seed = s;
    step();
    lat_ok = bus.m00_axis_tvalid; busy_ok = busy;
    start = 1'b0;
    guard = 0;
    while (wr_data_q.size() < BL && guard < LIMIT) begin
      if (spam) begin start = 1'($urandom_range(0, 1)); seed = $urandom; end
      case (wr_mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.m00_axis_tready = rdy;
      stalled = bus.m00_axis_tvalid && !rdy;
      hd = bus.m00_axis_wr_tdata; hl = bus.m00_axis_tlast;
      if (bus.m00_axis_tvalid && rdy) begin
        wr_data_q.push_back(bus.m00_axis_wr_tdata);
        wr_last_q.push_back(bus.m00_axis_tlast);
      end
      step(); guard++;
      if (stalled && (!bus.m00_axis_tvalid || bus.m00_axis_wr_tdata !== hd || bus.m00_axis_tlast !== hl))
        hold_bad++;
    end
    if (guard >= LIMIT) to_flag = 1;
    guard = 0;
    while (!done && guard < LIMIT) begin
      if (bus.m00_axis_tvalid) extra_wr++;
      bus.m00_axis_tready = 1'b1;
      if (spam) begin start = 1'($urandom_range(0, 1)); seed = $urandom; end
      case (rd_mode)
        0:       vld = 1'b1;
        1:       vld = ($urandom_range(0, 3) != 0);
        2:       vld = 1'b0;
        default: vld = (guard >= 40);
      endcase
      if (n_rd >= BL) vld = 1'b0;
      bus.s00_axis_tvalid = vld;
      if (n_rd < BL) begin
        if (loopback) begin
          bus.s00_axis_rd_tdata = (n_rd < wr_data_q.size()) ? wr_data_q[n_rd] : 32'h0;
          bus.s00_axis_tlast    = (n_rd < wr_last_q.size()) ? wr_last_q[n_rd] : 1'b0;
        end else begin
          bus.s00_axis_rd_tdata = rd_src_data[n_rd];
          bus.s00_axis_tlast    = rd_src_last[n_rd];
        end
      end
      fired = vld && bus.s00_axis_tready;
      step(); guard++; rd_cycles++;
      if (fired) begin err_trace[n_rd] = err_count; n_rd++; end
    end
    if (!done) to_flag = 1;
    done_seen = done; pass_o = pass; err_o = err_count;
    bus.s00_axis_tvalid = 1'b0; start = 1'b0;
    step();
    done_after = done; busy_after = busy; pass_hold = pass; err_hold = err_count;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step(); step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
    n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0b exp 0", pass); end
    n_tests++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_count); end
    n_tests++; if ({bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_wr_tdata, bus.s00_axis_tready} !== '0)
      begin n_fail++; $display("FAIL reset_stream got v%0b l%0b s%h d%h r%0b exp all 0", bus.m00_axis_tvalid,
        bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_wr_tdata, bus.s00_axis_tready); end
    areset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] s = 32'h0000_0100;
    loopback = 1'b1;
    do_run(s, 0, 0, 1'b0);
    n_tests++; if (lat_ok !== 1'b1 || busy_ok !== 1'b1) begin n_fail++; $display("FAIL basic_start_latency got valid %0b busy %0b exp 1 1", lat_ok, busy_ok); end
    n_tests++; if (bus.m00_axis_tstrb !== 4'h0) begin n_fail++; $display("FAIL basic_idle_strb got %h exp 0", bus.m00_axis_tstrb); end
    n_tests++; if (wr_data_q.size() !== BL) begin n_fail++; $display("FAIL basic_wr_count got %0d exp %0d", wr_data_q.size(), BL); end
    for (int i = 0; i < BL; i++) begin
      n_tests++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== s + 32'(i) || wr_last_q[i] !== (i == BL - 1)) begin
        n_fail++; $display("FAIL basic_wr_beat%0d got %h/%0b exp %h/%0b", i,
          (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, (i < wr_last_q.size()) ? wr_last_q[i] : 1'bx, s + 32'(i), i == BL - 1);
      end
    end
    n_tests++; if (rd_cycles !== BL) begin n_fail++; $display("FAIL basic_done_latency got %0d exp %0d", rd_cycles, BL); end
    n_tests++; if ({done_seen, pass_o, err_o} !== {1'b1, 1'b1, 13'd0}) begin n_fail++; $display("FAIL basic_result got done %0b pass %0b err %0d exp 1 1 0", done_seen, pass_o, err_o); end
    n_tests++; if ({done_after, busy_after, pass_hold} !== 3'b001) begin n_fail++; $display("FAIL basic_done_pulse got done %0b busy %0b pass %0b exp 0 0 1", done_after, busy_after, pass_hold); end
  endtask

  task automatic test_write_stall();
    logic [31:0] s = $urandom;
    loopback = 1'b1;
    do_run(s, 1, 0, 1'b1);
    n_tests++; if (hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable stalls exp 0", hold_bad); end
    n_tests++; if (wr_data_q.size() !== BL || extra_wr !== 0) begin n_fail++; $display("FAIL stall_count got %0d+%0d exp %0d+0", wr_data_q.size(), extra_wr, BL); end
    for (int i = 0; i < BL; i++) begin
      n_tests++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== s + 32'(i) || wr_last_q[i] !== (i == BL - 1)) begin
        n_fail++; $display("FAIL stall_wr_beat%0d got %h exp %h", i, (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, s + 32'(i));
      end
    end
    n_tests++; if ({pass_o, err_o} !== {1'b1, 13'd0}) begin n_fail++; $display("FAIL stall_result got pass %0b err %0d exp 1 0", pass_o, err_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] s = 32'hFFFF_FFFE;
    logic [31:0] exp_d[BL] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    loopback = 1'b1;
    do_run(s, 0, 1, 1'b0);
    for (int i = 0; i < BL; i++) begin
      n_tests++;
      if (i >= wr_data_q.size() || wr_data_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL wrap_beat%0d got %h exp %h", i, (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, exp_d[i]);
      end
    end
    n_tests++; if ({pass_o, err_o} !== {1'b1, 13'd0}) begin n_fail++; $display("FAIL wrap_result got pass %0b err %0d exp 1 0", pass_o, err_o); end
  endtask

  task automatic test_corrupt();
    logic [31:0] s = 32'h0000_2000;
    logic [CW-1:0] exp_tr[BL] = '{13'd0, 13'd1, 13'd2, 13'd2};
    loopback = 1'b0;
    for (int i = 0; i < BL; i++) begin rd_src_data[i] = s + 32'(i); rd_src_last[i] = (i == BL - 1); end
    rd_src_data[2] = 32'hDEAD_BEEF;
    rd_src_last[1] = 1'b1;
    do_run(s, 0, 0, 1'b0);
    n_tests++; if ({done_seen, pass_o, err_o} !== {1'b1, 1'b0, 13'd2}) begin n_fail++; $display("FAIL corrupt_result got done %0b pass %0b err %0d exp 1 0 2", done_seen, pass_o, err_o); end
    for (int i = 0; i < BL; i++) begin
      n_tests++; if (err_trace[i] !== exp_tr[i]) begin n_fail++; $display("FAIL corrupt_trace%0d got %0d exp %0d", i, err_trace[i], exp_tr[i]); end
    end
    n_tests++; if ({pass_hold, err_hold} !== {1'b0, 13'd2}) begin n_fail++; $display("FAIL corrupt_hold got pass %0b err %0d exp 0 2", pass_hold, err_hold); end
  endtask

  task automatic test_random();
    logic [31:0] s;
    int unsigned exp_e;
    loopback = 1'b0;
    for (int r = 0; r < 8; r++) begin
      s = $urandom;
      for (int i = 0; i < BL; i++) begin
        rd_src_data[i] = s + 32'(i);
        rd_src_last[i] = (i == BL - 1);
        if ($urandom_range(0, 3) == 0) rd_src_data[i] = rd_src_data[i] ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) rd_src_last[i] = ~rd_src_last[i];
      end
      exp_e = model_errs(s);
      do_run(s, 2, 1, 1'b1);
      n_tests++; if (wr_data_q.size() !== BL || hold_bad !== 0 || extra_wr !== 0 || to_flag !== 0)
        begin n_fail++; $display("FAIL rand%0d_write got beats %0d stalls_bad %0d extra %0d to %0d exp %0d 0 0 0", r, wr_data_q.size(), hold_bad, extra_wr, to_flag, BL); end
      for (int i = 0; i < BL; i++) begin
        n_tests++;
        if (i >= wr_data_q.size() || wr_data_q[i] !== s + 32'(i) || wr_last_q[i] !== (i == BL - 1)) begin
          n_fail++; $display("FAIL rand%0d_wr_beat%0d got %h exp %h", r, i, (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, s + 32'(i));
        end
      end
      n_tests++; if (err_o !== CW'(exp_e) || pass_o !== (exp_e == 0))
        begin n_fail++; $display("FAIL rand%0d_result got err %0d pass %0b exp %0d %0b", r, err_o, pass_o, exp_e, exp_e == 0); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] s = 32'h1234_5670;
    start = 1'b1; seed = 32'hAAAA_0000;
    step();
    start = 1'b0; bus.m00_axis_tready = 1'b1;
    step(); step();
    n_tests++; if (bus.m00_axis_wr_tdata !== 32'hAAAA_0002) begin n_fail++; $display("FAIL midrst_beat2 got %h exp aaaa0002", bus.m00_axis_wr_tdata); end
    areset = 1'b1;
    step();
    n_tests++; if ({busy, done, pass, err_count, bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_wr_tdata, bus.s00_axis_tready} !== '0)
      begin n_fail++; $display("FAIL midrst_outputs got busy %0b v %0b d %h strb %h exp all 0", busy, bus.m00_axis_tvalid, bus.m00_axis_wr_tdata, bus.m00_axis_tstrb); end
    areset = 1'b0;
    step();
    loopback = 1'b1;
    do_run(s, 0, 0, 1'b0);
    n_tests++; if (wr_data_q.size() !== BL || wr_data_q[0] !== s || wr_data_q[BL-1] !== s + 32'(BL - 1))
      begin n_fail++; $display("FAIL midrst_rerun_data got %0d beats first %h exp %0d beats first %h", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, BL, s); end
    n_tests++; if ({done_seen, pass_o, err_o} !== {1'b1, 1'b1, 13'd0}) begin n_fail++; $display("FAIL midrst_rerun_result got done %0b pass %0b err %0d exp 1 1 0", done_seen, pass_o, err_o); end
  endtask

  task automatic test_read_stall();
    loopback = 1'b1;
`ifdef AXIS_EXER_WATCHDOG_EN
    do_run(32'h0BAD_0000, 0, 2, 1'b0);
    n_tests++; if (rd_cycles !== TO) begin n_fail++; $display("FAIL watchdog_latency got %0d exp %0d", rd_cycles, TO); end
    n_tests++; if ({done_seen, pass_o, err_o} !== {1'b1, 1'b0, 13'(BL)}) begin n_fail++; $display("FAIL watchdog_result got done %0b pass %0b err %0d exp 1 0 %0d", done_seen, pass_o, err_o, BL); end
`else
    do_run(32'h0BAD_0000, 0, 3, 1'b0);
    n_tests++; if (rd_cycles !== 40 + BL) begin n_fail++; $display("FAIL read_wait_latency got %0d exp %0d", rd_cycles, 40 + BL); end
    n_tests++; if ({done_seen, pass_o, err_o} !== {1'b1, 1'b1, 13'd0}) begin n_fail++; $display("FAIL read_wait_result got done %0b pass %0b err %0d exp 1 1 0", done_seen, pass_o, err_o); end
`endif
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; seed = '0; loopback = 1'b1;
    bus.m00_axis_tready = 1'b0; bus.s00_axis_tvalid = 1'b0; bus.s00_axis_tlast = 1'b0;
    bus.s00_axis_rd_tdata = '0; bus.s00_axis_tstrb = '1;
    test_reset();
    test_basic();
    test_write_stall();
    test_wrap();
    test_corrupt();
    test_random();
    test_reset_midburst();
    test_read_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish within 50000 cycles");
    $fatal(1, "timeout");
  end

endmodule
